exc_ctrl: RTL and testbench
===========================

# exc_ctrl

Pipeline exception controller: samples exception flags of the instruction in MEM, arbitrates them by priority against the pending hardware/software interrupt, and drives the CP0 register block (excepttype, PC, delay-slot, bad address) together with the pipeline flush/redirect and stall vector. It sits between the MEM stage, the CP0 register block and the PC/pipeline registers. After every taken exception it runs a short recovery sequence that blocks re-triggering while the CP0 EXL update propagates.

## Interface
- EXC_VECTOR, 32'hBFC00380: redirect target for every exception except eret.
- RECOVER_CYCLES, 2: cycles after a taken exception during which no exception or interrupt is accepted. Legal range is ≥1.
- clk  in  1  clock.
- rst  in  1  reset. Synchronous and active-high; `RstEnable` = 1'b1.
- mem_valid_i  in  1  MEM holds a real (non-bubble) instruction.
- mem_pc_i  in  32  PC of the MEM instruction.
- mem_in_delayslot_i  in  1  MEM instruction is in a delay slot.
- mem_bad_addr_i  in  32  data access address of the MEM instruction.
- exc_adel_if_i, exc_ri_i, exc_ov_i, exc_tr_i, exc_sys_i, exc_bp_i, exc_adel_i, exc_ades_i, exc_eret_i  in  1 each  exception flags carried down the pipeline.
- cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current CP0 register values.
- wb_cp0_we_i  in  1  in-flight mtc0 in WB.
- wb_cp0_waddr_i  in  5  its CP0 address.
- wb_cp0_data_i  in  32  its CP0 data.
- stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i  in  1 each  stall requests.
- excepttype_o  out  32  exception code to CP0; 0 = none.
- current_inst_addr_o  out  32  = mem_pc_i.
- is_in_delayslot_o  out  1  = mem_in_delayslot_i.
- bad_addr_o  out  32  faulting address.
- flush_o  out  1  flush all pipeline registers.
- new_pc_o  out  32  redirect PC; valid while flush_o = 1.
- stall_o  out  6  {wb, mem, ex, id, if, pc} stall bits.

## Operation
- Effective status, cause and epc are the CP0 inputs, with WB forwarding applied (see Configuration). Forwarding to cause replaces bits 9:8 only.
- Interrupt condition: status[0] = 1, status[1] = 0, and (cause[15:8] & status[15:8]) ≠ 0.
- int_pending_q is registered from the interrupt condition every cycle. It is cleared on rst and while the FSM is in RECOVER.
- Priority when in IDLE and mem_valid_i = 1, highest first:
  - int_pending_q → 0x01
  - adel_if → 0x04, with bad_addr_o = mem_pc_i
  - ri → 0x0a
  - ov → 0x0c
  - tr → 0x0d
  - sys → 0x08
  - bp → 0x09
  - adel → 0x04, with bad_addr_o = mem_bad_addr_i
  - ades → 0x05, with bad_addr_o = mem_bad_addr_i
  - eret → 0x0e
- Otherwise excepttype_o = 0 and bad_addr_o = mem_bad_addr_i.
- Take = excepttype_o ≠ 0. On take, flush_o = 1 and stall_o = 0. new_pc_o = effective epc for 0x0e, else EXC_VECTOR.
- FSM states:
  - IDLE: goes to RECOVER on take, loading cnt = RECOVER_CYCLES-1.
  - RECOVER: excepttype_o = 0 and flush_o = 0. Returns to IDLE when cnt = 0, else cnt decrements.
- Stall arbitration, applied when not taking:
  - stallreq_mem → 011111
  - else stallreq_ex → 001111
  - else stallreq_id → 000111
  - else stallreq_if → 000011
  - else 000000
  - Stall arbitration applies in RECOVER as well.
- Simultaneous events:
  - Take overrides any stall request.
  - A bubble (mem_valid_i = 0) never takes, even with int_pending_q = 1. The interrupt stays pending until a valid instruction reaches MEM.

## Timing
- excepttype_o, flush_o, new_pc_o and stall_o are combinational from the current cycle's MEM inputs and registered state. CP0 captures excepttype_o at the same clock edge at which the pipeline flushes.
- Interrupt latency is 1 cycle from the interrupt condition to int_pending_q, plus the wait for a valid MEM instruction.
- After a take, the next take is possible no earlier than RECOVER_CYCLES+1 cycles later.
- Reset values: FSM = IDLE, cnt = 0, int_pending_q = 0.
- Outputs during rst: excepttype_o = 0, flush_o = 0, new_pc_o = 0, stall_o = 0, bad_addr_o = 0.
- rst asserted mid-RECOVER returns the FSM to IDLE on the next edge.

## Configuration
- EXC_CP0_FWD_EN defined: when wb_cp0_we_i = 1 and wb_cp0_waddr_i matches STATUS, CAUSE or EPC (12/13/14), the effective register takes wb_cp0_data_i. This covers mtc0 followed immediately by eret or an interrupt enable.
- EXC_CP0_FWD_EN undefined: the raw cp0_*_i values are used and the WB inputs are ignored.

## Test plan
- ov = 1, mem_pc_i = 0x80000010, delay slot = 0 → excepttype_o = 0x0c, flush_o = 1, new_pc_o = 0xBFC00380. Next 2 cycles: ov = 1 is ignored.
- status = 0x0000FF01 and cause[10] set, with a bubble in MEM for 3 cycles and then a valid instruction → excepttype_o = 0x01 only on the first valid cycle.
- adel_if and ov set together at pc = 0x80000003 → excepttype_o = 0x04, bad_addr_o = 0x80000003.
- eret with WB mtc0 EPC = 0x80001234 (EXC_CP0_FWD_EN defined) → new_pc_o = 0x80001234. With the macro undefined → new_pc_o = cp0_epc_i.
- stallreq_ex and stallreq_id both set → stall_o = 001111. Adding sys → stall_o = 0, flush_o = 1.
- rst raised for 1 cycle during RECOVER → IDLE; an exception on the following cycle is taken.

Source files
------------

// File: rtl/exc_ctrl.sv
// Pipeline exception controller: prioritises MEM-stage exceptions and interrupts, drives CP0 and flush/stall.
// Optional macro EXC_CP0_FWD_EN forwards an in-flight WB mtc0 into the effective status/cause/epc.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR     = 32'hBFC00380,
  parameter int          RECOVER_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [31:0] mem_bad_addr_i,
  input  logic        exc_adel_if_i,
  input  logic        exc_ri_i,
  input  logic        exc_ov_i,
  input  logic        exc_tr_i,
  input  logic        exc_sys_i,
  input  logic        exc_bp_i,
  input  logic        exc_adel_i,
  input  logic        exc_ades_i,
  input  logic        exc_eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [5:0]  stall_o
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_RECOVER = 1'b1;
  localparam int CNT_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RECOVER_CYCLES - 1);

  logic [0:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             int_pending_q;
  logic [31:0]      status_eff, cause_eff, epc_eff;
  logic [31:0]      exc_code, bad_addr;
  logic [5:0]       stall_arb;
  logic             int_cond, take;

`ifdef EXC_CP0_FWD_EN
  // Only the software interrupt bits of cause are writable by mtc0.
  always_comb begin
    status_eff = cp0_status_i;
    cause_eff  = cp0_cause_i;
    epc_eff    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      case (wb_cp0_waddr_i)
        5'd12:   status_eff = wb_cp0_data_i;
        5'd13:   cause_eff[9:8] = wb_cp0_data_i[9:8];
        5'd14:   epc_eff = wb_cp0_data_i;
        default: ;
      endcase
    end
  end
`else
  logic unused_wb;
  assign status_eff = cp0_status_i;
  assign cause_eff  = cp0_cause_i;
  assign epc_eff    = cp0_epc_i;
  assign unused_wb  = ^{wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i};
`endif

  logic unused_bits;
  assign unused_bits = ^{status_eff[31:16], status_eff[7:2], cause_eff[31:16], cause_eff[7:0]};

  assign int_cond = status_eff[0] & ~status_eff[1] & (|(cause_eff[15:8] & status_eff[15:8]));

  always_comb begin
    exc_code = 32'h0;
    bad_addr = mem_bad_addr_i;
    if (state_reg == ST_IDLE && mem_valid_i) begin
      if (int_pending_q)       exc_code = 32'h01;
      else if (exc_adel_if_i) begin
        exc_code = 32'h04;
        bad_addr = mem_pc_i;
      end
      else if (exc_ri_i)       exc_code = 32'h0a;
      else if (exc_ov_i)       exc_code = 32'h0c;
      else if (exc_tr_i)       exc_code = 32'h0d;
      else if (exc_sys_i)      exc_code = 32'h08;
      else if (exc_bp_i)       exc_code = 32'h09;
      else if (exc_adel_i)     exc_code = 32'h04;
      else if (exc_ades_i)     exc_code = 32'h05;
      else if (exc_eret_i)     exc_code = 32'h0e;
    end
  end

  assign take = (exc_code != 32'h0);

  always_comb begin
    if (stallreq_mem_i)      stall_arb = 6'b011111;
    else if (stallreq_ex_i)  stall_arb = 6'b001111;
    else if (stallreq_id_i)  stall_arb = 6'b000111;
    else if (stallreq_if_i)  stall_arb = 6'b000011;
    else                     stall_arb = 6'b000000;
  end

  assign current_inst_addr_o = mem_pc_i;
  assign is_in_delayslot_o   = mem_in_delayslot_i;

  always_comb begin
    excepttype_o = 32'h0;
    bad_addr_o   = 32'h0;
    flush_o      = 1'b0;
    new_pc_o     = 32'h0;
    stall_o      = 6'b0;
    if (!rst) begin
      excepttype_o = exc_code;
      bad_addr_o   = bad_addr;
      flush_o      = take;
      stall_o      = take ? 6'b0 : stall_arb;
      if (take) new_pc_o = (exc_code == 32'h0e) ? epc_eff : EXC_VECTOR;
    end
  end

  // RECOVER holds off re-triggering while CP0 EXL settles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      int_pending_q <= 1'b0;
    end else begin
      int_pending_q <= (state_reg == ST_RECOVER) ? 1'b0 : int_cond;
      case (state_reg)
        ST_IDLE: begin
          if (take) begin
            state_reg <= ST_RECOVER;
            cnt_reg   <= CNT_LOAD;
          end
        end
        default: begin
          if (cnt_reg == '0) state_reg <= ST_IDLE;
          else               cnt_reg   <= cnt_reg - 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_exc_ctrl;
  localparam logic [31:0] VEC = 32'hBFC00380;
  localparam int RC = 2;

  logic clk = 0;
  logic rst;
  logic mem_valid_i, mem_in_delayslot_i;
  logic [31:0] mem_pc_i, mem_bad_addr_i;
  logic exc_adel_if_i, exc_ri_i, exc_ov_i, exc_tr_i, exc_sys_i, exc_bp_i, exc_adel_i, exc_ades_i, exc_eret_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic wb_cp0_we_i;
  logic [4:0] wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
  logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o;
  logic is_in_delayslot_o, flush_o;
  logic [5:0] stall_o;

  int total = 0;
  int bad = 0;
  int m_block = 0;
  logic m_pend = 0;

  exc_ctrl #(.EXC_VECTOR(VEC), .RECOVER_CYCLES(RC)) dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i), .mem_in_delayslot_i(mem_in_delayslot_i),
    .mem_bad_addr_i(mem_bad_addr_i),
    .exc_adel_if_i(exc_adel_if_i), .exc_ri_i(exc_ri_i), .exc_ov_i(exc_ov_i), .exc_tr_i(exc_tr_i),
    .exc_sys_i(exc_sys_i), .exc_bp_i(exc_bp_i), .exc_adel_i(exc_adel_i), .exc_ades_i(exc_ades_i),
    .exc_eret_i(exc_eret_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
    .stallreq_if_i(stallreq_if_i), .stallreq_id_i(stallreq_id_i), .stallreq_ex_i(stallreq_ex_i),
    .stallreq_mem_i(stallreq_mem_i),
    .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
    .is_in_delayslot_o(is_in_delayslot_o), .bad_addr_o(bad_addr_o), .flush_o(flush_o),
    .new_pc_o(new_pc_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  task automatic eff_regs(output logic [31:0] st, output logic [31:0] ca, output logic [31:0] ep);
    st = cp0_status_i; ca = cp0_cause_i; ep = cp0_epc_i;
`ifdef EXC_CP0_FWD_EN
    if (wb_cp0_we_i) begin
      if (wb_cp0_waddr_i == 5'd12) st = wb_cp0_data_i;
      if (wb_cp0_waddr_i == 5'd13) ca[9:8] = wb_cp0_data_i[9:8];
      if (wb_cp0_waddr_i == 5'd14) ep = wb_cp0_data_i;
    end
`endif
  endtask

  // Reference outputs from the priority table and the model's blocking/pending state.
  task automatic model_out(output logic [31:0] e, output logic [31:0] b, output logic f,
                           output logic [31:0] np, output logic [5:0] sv);
    logic [31:0] st, ca, ep;
    logic flags [10];
    logic [31:0] codes [10];
    int n;
    bit found;
    codes = '{32'h01, 32'h04, 32'h0a, 32'h0c, 32'h0d, 32'h08, 32'h09, 32'h04, 32'h05, 32'h0e};
    flags = '{m_pend, exc_adel_if_i, exc_ri_i, exc_ov_i, exc_tr_i, exc_sys_i, exc_bp_i,
              exc_adel_i, exc_ades_i, exc_eret_i};
    eff_regs(st, ca, ep);
    e = 0; b = 0; f = 0; np = 0; sv = 0;
    if (rst) return;
    b = mem_bad_addr_i;
    found = 0;
    if (m_block == 0 && mem_valid_i) begin
      for (int i = 0; i < 10; i++) begin
        if (!found && flags[i]) begin
          found = 1;
          e = codes[i];
          if (i == 1) b = mem_pc_i;
        end
      end
    end
    f = (e != 0);
    if (f) np = (e == 32'h0e) ? ep : VEC;
    n = stallreq_mem_i ? 5 : stallreq_ex_i ? 4 : stallreq_id_i ? 3 : stallreq_if_i ? 2 : 0;
    sv = f ? 6'd0 : 6'((1 << n) - 1);
  endtask

  // One clock edge; advances the reference model with the inputs present at the edge.
  task automatic tick();
    logic [31:0] e, b, np, st, ca, ep;
    logic f, cond;
    logic [5:0] sv;
    model_out(e, b, f, np, sv);
    eff_regs(st, ca, ep);
    cond = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 0);
    @(posedge clk);
    if (rst) begin
      m_block = 0; m_pend = 0;
    end else begin
      m_pend = (m_block > 0) ? 1'b0 : cond;
      if (m_block > 0) m_block--;
      else if (f) m_block = RC;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rst = 0; mem_valid_i = 0; mem_in_delayslot_i = 0; mem_pc_i = 0; mem_bad_addr_i = 0;
    exc_adel_if_i = 0; exc_ri_i = 0; exc_ov_i = 0; exc_tr_i = 0; exc_sys_i = 0; exc_bp_i = 0;
    exc_adel_i = 0; exc_ades_i = 0; exc_eret_i = 0;
    cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
    wb_cp0_we_i = 0; wb_cp0_waddr_i = 0; wb_cp0_data_i = 0;
    stallreq_if_i = 0; stallreq_id_i = 0; stallreq_ex_i = 0; stallreq_mem_i = 0;
  endtask

  task automatic settle();
    clear_inputs();
    repeat (RC + 2) tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; mem_valid_i = 1; exc_ov_i = 1; stallreq_mem_i = 1; mem_bad_addr_i = 32'h1234;
    #1;
    total++;
    if (excepttype_o !== 0 || flush_o !== 0 || new_pc_o !== 0 || stall_o !== 0 || bad_addr_o !== 0) begin
      bad++;
      $display("FAIL reset_outputs: got exc=%h flush=%b npc=%h stall=%b bad=%h, want all zero",
               excepttype_o, flush_o, new_pc_o, stall_o, bad_addr_o);
    end
    tick(); tick();
    clear_inputs();
    #1;
    total++;
    if (excepttype_o !== 0 || flush_o !== 0 || stall_o !== 0) begin
      bad++;
      $display("FAIL reset_idle: got exc=%h flush=%b stall=%b, want 0/0/0", excepttype_o, flush_o, stall_o);
    end
    $display("reset: exc=%h flush=%b stall=%b", excepttype_o, flush_o, stall_o);
    tick();
  endtask

  task automatic test_ov_recover();
    settle();
    mem_valid_i = 1; mem_pc_i = 32'h80000010; exc_ov_i = 1;
    #1;
    total++;
    if (excepttype_o !== 32'h0c || flush_o !== 1 || new_pc_o !== VEC) begin
      bad++;
      $display("FAIL ov_take: got exc=%h flush=%b npc=%h, want 0c/1/%h", excepttype_o, flush_o, new_pc_o, VEC);
    end
    $display("ov take: exc=%h flush=%b npc=%h", excepttype_o, flush_o, new_pc_o);
    tick();
    for (int c = 0; c < RC; c++) begin
      #1;
      total++;
      if (excepttype_o !== 0 || flush_o !== 0) begin
        bad++;
        $display("FAIL ov_recover%0d: got exc=%h flush=%b, want 0/0", c, excepttype_o, flush_o);
      end
      tick();
    end
    #1;
    total++;
    if (excepttype_o !== 32'h0c || flush_o !== 1) begin
      bad++;
      $display("FAIL ov_retake: got exc=%h flush=%b, want 0c/1", excepttype_o, flush_o);
    end
    $display("ov retake after %0d cycles: exc=%h", RC + 1, excepttype_o);
    tick();
  endtask

  task automatic test_int_bubble();
    settle();
    cp0_status_i = 32'h0000FF01; cp0_cause_i = 32'h00000400;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (excepttype_o !== 0 || flush_o !== 0) begin
        bad++;
        $display("FAIL int_bubble%0d: got exc=%h flush=%b, want 0/0", c, excepttype_o, flush_o);
      end
      tick();
    end
    mem_valid_i = 1; mem_pc_i = 32'h80000100;
    #1;
    total++;
    if (excepttype_o !== 32'h01 || flush_o !== 1 || new_pc_o !== VEC) begin
      bad++;
      $display("FAIL int_take: got exc=%h flush=%b npc=%h, want 01/1/%h", excepttype_o, flush_o, new_pc_o, VEC);
    end
    $display("int take: exc=%h", excepttype_o);
    tick();
    #1;
    total++;
    if (excepttype_o !== 0) begin
      bad++;
      $display("FAIL int_once: got exc=%h, want 0", excepttype_o);
    end
    tick();
  endtask

  task automatic test_adel_if_priority();
    settle();
    mem_valid_i = 1; mem_pc_i = 32'h80000003; mem_bad_addr_i = 32'h12345678;
    exc_adel_if_i = 1; exc_ov_i = 1;
    #1;
    total++;
    if (excepttype_o !== 32'h04 || bad_addr_o !== 32'h80000003) begin
      bad++;
      $display("FAIL adel_if: got exc=%h bad=%h, want 04/80000003", excepttype_o, bad_addr_o);
    end
    $display("adel_if+ov: exc=%h bad=%h", excepttype_o, bad_addr_o);
    tick();
  endtask

  task automatic test_eret_fwd();
    logic [31:0] want;
    settle();
    mem_valid_i = 1; mem_pc_i = 32'h80000200; exc_eret_i = 1; cp0_epc_i = 32'h80000AAA;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h80001234;
`ifdef EXC_CP0_FWD_EN
    want = 32'h80001234;
`else
    want = 32'h80000AAA;
`endif
    #1;
    total++;
    if (excepttype_o !== 32'h0e || new_pc_o !== want) begin
      bad++;
      $display("FAIL eret: got exc=%h npc=%h, want 0e/%h", excepttype_o, new_pc_o, want);
    end
    $display("eret: exc=%h npc=%h", excepttype_o, new_pc_o);
    tick();
  endtask

  task automatic test_stall();
    settle();
    mem_valid_i = 1; stallreq_ex_i = 1; stallreq_id_i = 1;
    #1;
    total++;
    if (stall_o !== 6'b001111 || flush_o !== 0) begin
      bad++;
      $display("FAIL stall_ex_id: got stall=%b flush=%b, want 001111/0", stall_o, flush_o);
    end
    $display("stall ex+id: stall=%b", stall_o);
    exc_sys_i = 1;
    #1;
    total++;
    if (stall_o !== 6'b0 || flush_o !== 1 || excepttype_o !== 32'h08) begin
      bad++;
      $display("FAIL stall_sys: got stall=%b flush=%b exc=%h, want 000000/1/08", stall_o, flush_o, excepttype_o);
    end
    tick();
    exc_sys_i = 0;
    #1;
    total++;
    if (stall_o !== 6'b001111 || flush_o !== 0) begin
      bad++;
      $display("FAIL stall_recover: got stall=%b flush=%b, want 001111/0", stall_o, flush_o);
    end
    tick();
  endtask

  task automatic test_rst_recover();
    settle();
    mem_valid_i = 1; exc_ov_i = 1;
    #1;
    total++;
    if (excepttype_o !== 32'h0c) begin
      bad++;
      $display("FAIL rstrec_take: got exc=%h, want 0c", excepttype_o);
    end
    tick();
    rst = 1;
    tick();
    rst = 0;
    #1;
    total++;
    if (excepttype_o !== 32'h0c || flush_o !== 1) begin
      bad++;
      $display("FAIL rstrec_after: got exc=%h flush=%b, want 0c/1", excepttype_o, flush_o);
    end
    $display("rst during recover then ov: exc=%h", excepttype_o);
    tick();
  endtask

  task automatic test_random();
    logic [31:0] e, b, np;
    logic f;
    logic [5:0] sv;
    int cyc_bad;
    clear_inputs();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      mem_valid_i = ($urandom_range(0, 3) != 0);
      mem_pc_i = $urandom; mem_bad_addr_i = $urandom; mem_in_delayslot_i = 1'($urandom);
      exc_adel_if_i = ($urandom_range(0, 15) == 0); exc_ri_i = ($urandom_range(0, 15) == 0);
      exc_ov_i = ($urandom_range(0, 15) == 0);      exc_tr_i = ($urandom_range(0, 15) == 0);
      exc_sys_i = ($urandom_range(0, 15) == 0);     exc_bp_i = ($urandom_range(0, 15) == 0);
      exc_adel_i = ($urandom_range(0, 15) == 0);    exc_ades_i = ($urandom_range(0, 15) == 0);
      exc_eret_i = ($urandom_range(0, 15) == 0);
      cp0_status_i = {16'h0, 8'($urandom), 6'h0, ($urandom_range(0, 3) == 0), 1'($urandom)};
      cp0_cause_i = {16'h0, ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h0, 8'h0};
      cp0_epc_i = $urandom;
      wb_cp0_we_i = ($urandom_range(0, 3) == 0);
      wb_cp0_waddr_i = 5'($urandom_range(11, 15));
      wb_cp0_data_i = $urandom;
      stallreq_if_i = 1'($urandom); stallreq_id_i = ($urandom_range(0, 2) == 0);
      stallreq_ex_i = ($urandom_range(0, 3) == 0); stallreq_mem_i = ($urandom_range(0, 4) == 0);
      #1;
      model_out(e, b, f, np, sv);
      cyc_bad = 0;
      total++;
      if (excepttype_o !== e) begin
        bad++; cyc_bad++;
        $display("FAIL rand_exc cyc=%0d: got %h want %h", c, excepttype_o, e);
      end
      total++;
      if (flush_o !== f || new_pc_o !== np) begin
        bad++; cyc_bad++;
        $display("FAIL rand_flush cyc=%0d: got %b/%h want %b/%h", c, flush_o, new_pc_o, f, np);
      end
      total++;
      if (stall_o !== sv) begin
        bad++; cyc_bad++;
        $display("FAIL rand_stall cyc=%0d: got %b want %b", c, stall_o, sv);
      end
      total++;
      if (bad_addr_o !== b) begin
        bad++; cyc_bad++;
        $display("FAIL rand_bad_addr cyc=%0d: got %h want %h", c, bad_addr_o, b);
      end
      total++;
      if (current_inst_addr_o !== mem_pc_i || is_in_delayslot_o !== mem_in_delayslot_i) begin
        bad++; cyc_bad++;
        $display("FAIL rand_passthru cyc=%0d: got %h/%b want %h/%b", c, current_inst_addr_o,
                 is_in_delayslot_o, mem_pc_i, mem_in_delayslot_i);
      end
      $display("rand cyc=%0d rst=%b v=%b exc=%h flush=%b stall=%b errs=%0d",
               c, rst, mem_valid_i, excepttype_o, flush_o, stall_o, cyc_bad);
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    @(negedge clk);
    test_reset();
    test_ov_recover();
    test_int_bubble();
    test_adel_if_priority();
    test_eret_fwd();
    test_stall();
    test_rst_recover();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
